// File: rtl/mips_run_controller_if.sv
// Program-load stream and instruction-memory write port of the MIPS run controller.
interface mips_run_controller_if #(
   parameter int unsigned ADDR_W = 6
) ();
   logic              ld_valid;
   logic              ld_ready;
   logic [31:0]       ld_data;
   logic              ld_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   // master: program source / memory sink side; slave: the run controller
   modport master (
      output ld_valid, ld_data, ld_last,
      input  ld_ready, imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  ld_valid, ld_data, ld_last,
      output ld_ready, imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/mips_run_controller.sv
// Run control for the single-cycle MIPS core: streams a program into instruction
// memory, holds the core in reset until start, and stops on a halt PC or cycle budget.
module mips_run_controller #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned CNT_W   = 16,
   parameter logic [31:0] HALT_PC = 32'h0000_001C
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_run_controller_if.slave  ld,
   input  logic                  start,
   input  logic                  clear,
   input  logic [CNT_W-1:0]      run_limit,
   output logic                  core_reset,
   input  logic [31:0]           core_pc,
   output logic                  busy,
   output logic                  done,
   output logic                  halted,
   output logic                  timeout,
   output logic                  load_err,
   output logic [ADDR_W:0]       words_loaded,
   output logic [CNT_W-1:0]      cycle_count
);
   localparam int unsigned     WL_W      = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WL_W-1:0]   words_q, words_d;
   logic [CNT_W-1:0]  limit_q, limit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ld_ready_q, ld_ready_d;
   logic              core_reset_q, core_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic              err_q, err_d;
   logic              accept;
   logic [CNT_W-1:0]  cnt_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         words_q      <= '0;
         limit_q      <= '0;
         cnt_q        <= '0;
         ld_ready_q   <= 1'b0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         halted_q     <= 1'b0;
         timeout_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         words_q      <= words_d;
         limit_q      <= limit_d;
         cnt_q        <= cnt_d;
         ld_ready_q   <= ld_ready_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         halted_q     <= halted_d;
         timeout_q    <= timeout_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      words_d   = words_q;
      limit_d   = limit_q;
      cnt_d     = cnt_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      err_d     = err_q;
      accept    = ld.ld_valid && ld_ready_q;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               words_d = WL_W'(1);
               err_d   = 1'b0;
               if (ld.ld_last) begin
                  state_d = S_READY;
                  addr_d  = '0;
               end else begin
                  state_d = S_LOAD;
                  addr_d  = addr_q + ADDR_W'(1);
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               words_d = words_q + WL_W'(1);
               // Address counter returns to 0 so the next load starts at the bottom
               if (ld.ld_last) begin
                  state_d = S_READY;
                  addr_d  = '0;
               end else if (addr_q == LAST_ADDR) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  addr_d  = '0;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
               end
            end
         end
         S_READY: begin
            if (start) begin
               state_d   = S_RUN;
               limit_d   = run_limit;
               cnt_d     = '0;
               halted_d  = 1'b0;
               timeout_d = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            // Halt takes priority over an exhausted budget on the same edge
            if (core_pc == HALT_PC) begin
               state_d  = S_DONE;
               halted_d = 1'b1;
            end else if ((limit_q != '0) && (cnt_inc == limit_q)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: begin
            if (clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      ld_ready_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
      core_reset_d = (state_d != S_RUN);
      busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
   end

   assign ld.ld_ready   = ld_ready_q;
   assign ld.imem_we    = ld.ld_valid && ld_ready_q;
   assign ld.imem_waddr = addr_q;
   assign ld.imem_wdata = ld.ld_data;

   assign core_reset   = core_reset_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign halted       = halted_q;
   assign timeout      = timeout_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;
   assign cycle_count  = cnt_q;
endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: directed program loads and runs against a
// program-level run model and a toy core, plus an ADDR_W=3 overflow instance.
module tb_mips_run_controller;
   localparam int unsigned AW  = 6;
   localparam int unsigned AWB = 3;
   localparam int unsigned CW  = 16;
   localparam logic [31:0] HALT     = 32'h0000_001C;
   localparam logic [31:0] BEQ_SELF = 32'h1000_FFFF;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_run_controller_if #(.ADDR_W(AW))  ifa ();
   mips_run_controller_if #(.ADDR_W(AWB)) ifb ();

   logic          start_a, clear_a, core_reset_a, busy_a, done_a, halted_a, timeout_a, err_a;
   logic [CW-1:0] limit_a, cnt_a;
   logic [AW:0]   words_a;
   logic [31:0]   core_pc_a = 32'h0;

   logic          start_b, clear_b, core_reset_b, busy_b, done_b, halted_b, timeout_b, err_b;
   logic [CW-1:0] limit_b, cnt_b;
   logic [AWB:0]  words_b;
   logic [31:0]   core_pc_b;

   mips_run_controller #(.ADDR_W(AW), .CNT_W(CW), .HALT_PC(HALT)) dut_a (
      .clk(clk), .reset(reset), .ld(ifa.slave), .start(start_a), .clear(clear_a),
      .run_limit(limit_a), .core_reset(core_reset_a), .core_pc(core_pc_a),
      .busy(busy_a), .done(done_a), .halted(halted_a), .timeout(timeout_a),
      .load_err(err_a), .words_loaded(words_a), .cycle_count(cnt_a)
   );

   mips_run_controller #(.ADDR_W(AWB), .CNT_W(CW), .HALT_PC(HALT)) dut_b (
      .clk(clk), .reset(reset), .ld(ifb.slave), .start(start_b), .clear(clear_b),
      .run_limit(limit_b), .core_reset(core_reset_b), .core_pc(core_pc_b),
      .busy(busy_b), .done(done_b), .halted(halted_b), .timeout(timeout_b),
      .load_err(err_b), .words_loaded(words_b), .cycle_count(cnt_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Toy core: fetches from what the bench saw written; beq-to-self holds the PC
   logic [31:0] core_mem [0:63];
   always @(posedge clk) begin
      if (core_reset_a) core_pc_a <= 32'h0;
      else if (core_mem[core_pc_a[7:2]] == BEQ_SELF) core_pc_a <= core_pc_a;
      else core_pc_a <= core_pc_a + 32'd4;
   end

   // Per-cycle write-path and state-consistency checks
   int exp_addr_a = 0;
   int exp_addr_b = 0;
   int nwr_b = 0;
   logic [31:0] last_b = 32'h0;
   always @(negedge clk) begin
      if (reset) begin
         exp_addr_a = 0;
         exp_addr_b = 0;
      end else begin
         chk("a_we", ifa.imem_we, ifa.ld_valid && ifa.ld_ready);
         chk("a_wdata", ifa.imem_wdata, ifa.ld_data);
         if (ifa.imem_we) begin
            chk("a_waddr", ifa.imem_waddr, exp_addr_a);
            core_mem[exp_addr_a] = ifa.ld_data;
            exp_addr_a = ifa.ld_last ? 0 : (exp_addr_a + 1) % 64;
         end
         chk("a_core_reset_vs_run", core_reset_a, !(busy_a && !ifa.ld_ready));
         chk("a_busy_and_done", busy_a && done_a, 0);
         chk("b_we", ifb.imem_we, ifb.ld_valid && ifb.ld_ready);
         if (ifb.imem_we) begin
            chk("b_waddr", ifb.imem_waddr, exp_addr_b);
            nwr_b++;
            last_b = ifb.ld_data;
            exp_addr_b = ifb.ld_last ? 0 : (exp_addr_b + 1) % 8;
         end
      end
   end

   logic [31:0] prog    [0:7];
   logic [31:0] mdl_mem [0:63];

   // Run outcome from the program image: edge k sees the PC after k-1 steps
   task automatic model_run(input logic [CW-1:0] lim, output int cnt, output bit h, output bit t);
      logic [31:0] pc;
      pc = 32'h0; h = 0; t = 0; cnt = 0;
      for (int k = 1; k <= 60000; k++) begin
         if (pc == HALT) begin h = 1; cnt = k; break; end
         if (lim != 0 && k == int'(lim)) begin t = 1; cnt = k; break; end
         pc = (mdl_mem[pc[7:2]] == BEQ_SELF) ? pc : pc + 32'd4;
      end
   endtask

   task automatic load_a(input int n, input bit gaps, input bit poke_start);
      bit acc;
      for (int i = 0; i < n; i++) begin
         ifa.ld_valid = 1'b1;
         ifa.ld_data  = prog[i];
         ifa.ld_last  = (i == n - 1);
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) begin
            acc = ifa.ld_ready;
            @(posedge clk); #1;
         end
         chk("a_beat_accepted", acc, 1);
         mdl_mem[i] = prog[i];
         ifa.ld_valid = 1'b0;
         if (gaps) begin
            if (poke_start && i == 3) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            if (poke_start && i == 3) begin
               chk("start_in_load_busy", busy_a, 1);
               chk("start_in_load_core_reset", core_reset_a, 1);
               chk("start_in_load_ready", ifa.ld_ready, 1);
            end
         end
      end
      ifa.ld_last = 1'b0;
      chk("a_words_loaded", words_a, n);
      chk("a_ready_after_load", ifa.ld_ready, 0);
      chk("a_idle_after_load_busy", busy_a, 0);
   endtask

   task automatic run_a(input logic [CW-1:0] lim);
      int ecnt, cyc;
      bit eh, et;
      model_run(lim, ecnt, eh, et);
      limit_a = lim;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("run_core_reset_low", core_reset_a, 0);
      chk("run_busy", busy_a, 1);
      cyc = 0;
      while (!done_a && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("run_done_reached", done_a, 1);
      chk("run_edges", cyc, ecnt);
      chk("run_cycle_count", cnt_a, ecnt);
      chk("run_halted", halted_a, eh);
      chk("run_timeout", timeout_a, et);
      chk("run_core_reset_after", core_reset_a, 1);
      chk("run_busy_after", busy_a, 0);
   endtask

   task automatic clear_a_pulse();
      clear_a = 1'b1;
      @(posedge clk); #1;
      clear_a = 1'b0;
      chk("clear_done_low", done_a, 0);
      chk("clear_ld_ready", ifa.ld_ready, 1);
   endtask

   initial begin
      bit acc;
      ifa.ld_valid = 1'b0; ifa.ld_data = '0; ifa.ld_last = 1'b0;
      ifb.ld_valid = 1'b0; ifb.ld_data = '0; ifb.ld_last = 1'b0;
      start_a = 0; clear_a = 0; limit_a = '0;
      start_b = 0; clear_b = 0; limit_b = '0; core_pc_b = 32'h0;
      for (int i = 0; i < 64; i++) begin core_mem[i] = NOP; mdl_mem[i] = NOP; end
      for (int i = 0; i < 8; i++) prog[i] = NOP;

      repeat (2) @(posedge clk); #1;
      chk("rst_ld_ready", ifa.ld_ready, 0);
      chk("rst_core_reset", core_reset_a, 1);
      chk("rst_imem_we", ifa.imem_we, 0);
      chk("rst_imem_waddr", ifa.imem_waddr, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_flags", {halted_a, timeout_a, err_a}, 0);
      chk("rst_words", words_a, 0);
      chk("rst_cycle_count", cnt_a, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ld_ready", ifa.ld_ready, 1);

      // Eight nops, halt at 0x1C within a budget of 100
      load_a(8, 0, 0);
      run_a(16'd100);
      chk("p1_cycle_count_lit", cnt_a, 8);
      chk("p1_halted_lit", halted_a, 1);
      clear_a_pulse();
      chk("held_cycle_count", cnt_a, 8);
      chk("held_halted", halted_a, 1);

      // Gapped load with a stray start; budget equals halt edge so halt wins
      load_a(8, 1, 1);
      run_a(16'd8);
      chk("p6_timeout_lit", timeout_a, 0);
      chk("p6_cycle_count_lit", cnt_a, 8);
      clear_a_pulse();

      // Single-word spin loop runs out its budget
      prog[0] = BEQ_SELF;
      load_a(1, 0, 0);
      run_a(16'd20);
      chk("p2_timeout_lit", timeout_a, 1);
      chk("p2_halted_lit", halted_a, 0);
      chk("p2_cycle_count_lit", cnt_a, 20);
      clear_a_pulse();

      // Reset in the middle of a run
      prog[0] = NOP;
      load_a(8, 0, 0);
      limit_a = '0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("mid_run_core_reset", core_reset_a, 0);
      reset = 1'b1;
      #1;
      chk("async_core_reset", core_reset_a, 1);
      chk("async_ld_ready", ifa.ld_ready, 0);
      chk("async_cycle_count", cnt_a, 0);
      chk("async_busy", busy_a, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("release_ld_ready_low", ifa.ld_ready, 0);
      @(posedge clk); #1;
      chk("release_ld_ready_high", ifa.ld_ready, 1);
      chk("release_words", words_a, 0);

      // ADDR_W=3: nine words without ld_last overflow an 8-word memory
      for (int i = 0; i < 9; i++) begin
         ifb.ld_valid = 1'b1;
         ifb.ld_data  = 32'hB000_0001 + 32'(i);
         acc = 1'b0;
         for (int t = 0; t < 4 && !acc; t++) begin
            acc = ifb.ld_ready;
            @(posedge clk); #1;
         end
         chk("b_beat_accept", acc, (i < 8));
      end
      ifb.ld_valid = 1'b0;
      chk("b_load_err", err_b, 1);
      chk("b_done", done_b, 1);
      chk("b_ld_ready", ifb.ld_ready, 0);
      chk("b_words", words_b, 8);
      chk("b_write_count", nwr_b, 8);
      chk("b_last_word", last_b, 32'hB000_0008);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips_run_controller.md
# mips_run_controller

Run-control and program-load block for the single-cycle MIPS core. It accepts a program as a valid/ready word stream and writes it into instruction memory. It then holds the core in reset until `start`, releases it, and stops the run on a halt PC or a cycle budget, reporting status and cycle count. It replaces hierarchical memory pokes in benches and on the FPGA top, and scales in memory depth and counter width.

## Interface

- `ADDR_W`, 6: instruction-memory word-address width; depth = 2^ADDR_W words.
- `CNT_W`, 16: width of the cycle counter and the run limit.
- `HALT_PC`, 32'h0000_001C: byte PC that ends a run.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid && ld_ready`.
- `ld_data`  in  32  instruction word.
- `ld_last`  in  1  marks the final word of the program.
- `start`  in  1  single-cycle pulse; begins a run from READY.
- `clear`  in  1  single-cycle pulse; returns from DONE to IDLE.
- `run_limit`  in  CNT_W  cycle budget, sampled on `start`; 0 = unlimited.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_waddr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  write data.
- `core_reset`  out  1  drives the core's `reset`.
- `core_pc`  in  32  the core's current PC.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  high in DONE.
- `halted`  out  1  run ended on `HALT_PC`.
- `timeout`  out  1  run ended on the cycle budget.
- `load_err`  out  1  program exceeded the memory depth.
- `words_loaded`  out  ADDR_W+1  words written in the last load.
- `cycle_count`  out  CNT_W  core clock edges in the last run.

## Operation

- States: IDLE, LOAD, READY, RUN, DONE. Reset state is IDLE.
- Reset values: `ld_ready`=0, `core_reset`=1, `imem_we`=0, and all status flags and counters at 0. `imem_waddr` and `imem_wdata` follow the combinational rules below.
- `ld_ready` is registered. It is 1 in IDLE and LOAD, and is cleared on the edge that accepts the last or overflowing beat.
- Write path is combinational pass-through:
  - `imem_we = ld_valid && ld_ready`
  - `imem_waddr` = the word-address counter
  - `imem_wdata = ld_data`
- IDLE: the first accepted beat writes address 0 and clears `words_loaded` and `load_err`. Next state is LOAD, or READY if `ld_last`.
- LOAD: each accepted beat writes the next address and increments `words_loaded`.
  - Beat with `ld_last` → READY.
  - Beat at address 2^ADDR_W−1 without `ld_last` → DONE with `load_err`=1. That word is written; no further words are accepted.
- READY: `start` samples `run_limit`, clears `cycle_count`, `halted` and `timeout`, then → RUN.
- RUN: `core_reset`=0. On every edge, `cycle_count` increments (saturating at all-ones).
  - `core_pc == HALT_PC` → DONE, `halted`=1.
  - Else if `run_limit`≠0 and the incremented count equals `run_limit` → DONE, `timeout`=1.
  - If both conditions hold on the same edge, halt wins and `timeout` stays 0.
- DONE: `core_reset`=1. The core's reset clears its PC only; register file and data memory are retained for readback. `clear` → IDLE; status and counters are held until the next load or start.
- `start` outside READY and `clear` outside DONE are ignored. `core_reset` is 1 in every state except RUN.
- A program must place a nop at `HALT_PC`, because the word at `HALT_PC` executes once on the halting edge.

## Timing

- Load: one word per cycle at full throughput. Gaps in `ld_valid` are allowed; `ld_data` is written on the same edge it is accepted.
- `start` at edge N → `core_reset` falls after edge N; the core executes PC 0 on edge N+1.
- RUN edge k (k=1,2,…) sees `core_pc` = PC after k−1 core steps, and `cycle_count`=k after that edge.
- Halt/timeout edge → `core_reset`, `done` and the flags are all valid in the following cycle.
- Asserting `reset` in any state immediately sets `core_reset`=1 and `ld_ready`=0; after deassertion the block is in IDLE.

## Test plan

- Load 8 words (7 nops plus a nop at 0x1C) with `ld_last` on word 7, `run_limit`=100, then `start` → `words_loaded`=8, `halted`=1, `cycle_count`=8, `timeout`=0.
- Word 0 = 32'h1000FFFF (`beq $0,$0,-1`), `ld_last` on that word, `run_limit`=20 → `timeout`=1, `halted`=0, `cycle_count`=20, `core_reset`=1 afterwards.
- `ADDR_W`=3, stream 9 words without `ld_last` → addresses 0–7 written, `load_err`=1, `done`=1, `ld_ready`=0, word 9 never written, `words_loaded`=8.
- Toggle `ld_valid` every other cycle and pulse `start` during LOAD → writes only on handshakes, contiguous addresses, `start` ignored.
- Assert `reset` on RUN edge 3 of the first program → `core_reset`=1 immediately, state IDLE, `cycle_count`=0, `ld_ready`=1 one edge after release.
- First program with `run_limit`=8 → `halted`=1, `timeout`=0, `cycle_count`=8.
